// File: rtl/hex2ascii_if.sv
// Handshake bundle for hex2ascii_stream: word input channel and character output channel.
// The master side drives words and accepts characters; the slave side is the converter.
interface hex2ascii_if #(
   parameter int unsigned NBYTES = 2
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_char;
   logic                  out_last;
   logic                  busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_char, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_char, out_last, busy
   );
endinterface

// File: rtl/hex2ascii_stream.sv
// Converts a captured binary word into a stream of ASCII hex characters, MS nibble first,
// with optional "0x" prefix, leading-zero suppression and CR/LF terminator.
module hex2ascii_stream #(
   parameter int unsigned NBYTES      = 2,
   parameter bit          LOWERCASE   = 1'b0,
   parameter bit          PREFIX_EN   = 1'b0,
   parameter bit          LZ_SUPPRESS = 1'b0,
   parameter bit          CRLF_EN     = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   hex2ascii_if.slave bus
);
   localparam int unsigned W   = 8 * NBYTES;
   localparam int unsigned NIB = 2 * NBYTES;
   localparam int unsigned IW  = $clog2(NIB);

   typedef enum logic [2:0] {StIdle, StPfx0, StPfx1, StDig, StCr, StLf} state_e;

   state_e         state_q;
   logic [W-1:0]   word_q;
   logic [IW-1:0]  idx_q;
   logic [7:0]     char_q;
   logic           valid_q;
   logic           last_q;
   logic           busy_q;
   logic [IW-1:0]  first_idx;
   logic           hs;

   function automatic logic [3:0] nib_at(input logic [W-1:0] w, input logic [IW-1:0] i);
      logic [W-1:0] sh;
      sh = w >> {i, 2'b00};
      return sh[3:0];
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return (LOWERCASE ? 8'h57 : 8'h37) + {4'h0, n};
   endfunction

   // Highest non-zero nibble; a zero word still yields one digit at index 0.
   function automatic logic [IW-1:0] top_idx(input logic [W-1:0] d);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NIB); i++) begin
         if (d[i*4 +: 4] != 4'h0) r = IW'(i);
      end
      return r;
   endfunction

   always_comb begin
      first_idx = LZ_SUPPRESS ? top_idx(bus.in_data) : IW'(NIB - 1);
   end

   assign hs = valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         word_q  <= '0;
         idx_q   <= '0;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  word_q  <= bus.in_data;
                  idx_q   <= first_idx;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
                  if (PREFIX_EN) begin
                     state_q <= StPfx0;
                     char_q  <= 8'h30;
                     last_q  <= 1'b0;
                  end else begin
                     state_q <= StDig;
                     char_q  <= hex_char(nib_at(bus.in_data, first_idx));
                     last_q  <= (first_idx == '0) && !CRLF_EN;
                  end
               end
            end
            StPfx0: begin
               if (hs) begin
                  state_q <= StPfx1;
                  char_q  <= 8'h78;
               end
            end
            StPfx1: begin
               if (hs) begin
                  state_q <= StDig;
                  char_q  <= hex_char(nib_at(word_q, idx_q));
                  last_q  <= (idx_q == '0) && !CRLF_EN;
               end
            end
            StDig: begin
               if (hs) begin
                  if (idx_q == '0) begin
                     if (CRLF_EN) begin
                        state_q <= StCr;
                        char_q  <= 8'h0D;
                     end else begin
                        state_q <= StIdle;
                        char_q  <= 8'h00;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     idx_q  <= idx_q - 1'b1;
                     char_q <= hex_char(nib_at(word_q, idx_q - 1'b1));
                     last_q <= (idx_q == IW'(1)) && !CRLF_EN;
                  end
               end
            end
            StCr: begin
               if (hs) begin
                  state_q <= StLf;
                  char_q  <= 8'h0A;
                  last_q  <= 1'b1;
               end
            end
            StLf: begin
               if (hs) begin
                  state_q <= StIdle;
                  char_q  <= 8'h00;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = valid_q;
   assign bus.out_char  = char_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_hex2ascii_stream.sv
// Bench for hex2ascii_stream: four parameter variants share one stimulus bus, selected by sel.
// Expected {last,char} pairs are queued up front and compared against captured handshakes.
module tb_hex2ascii_stream;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] din = '0;
   logic [3:0]  vin = '0;
   logic        ordy = 1'b1;
   logic [1:0]  sel = 2'd0;

   always #5 clk = ~clk;

   hex2ascii_if #(.NBYTES(2)) if0 ();
   hex2ascii_if #(.NBYTES(2)) if1 ();
   hex2ascii_if #(.NBYTES(2)) if2 ();
   hex2ascii_if #(.NBYTES(4)) if3 ();

   assign if0.in_valid = vin[0];  assign if0.in_data = din[15:0];  assign if0.out_ready = ordy;
   assign if1.in_valid = vin[1];  assign if1.in_data = din[15:0];  assign if1.out_ready = ordy;
   assign if2.in_valid = vin[2];  assign if2.in_data = din[15:0];  assign if2.out_ready = ordy;
   assign if3.in_valid = vin[3];  assign if3.in_data = din[31:0];  assign if3.out_ready = ordy;

   hex2ascii_stream #(.NBYTES(2)) u_def (.clk(clk), .rst_n(rst_n), .bus(if0));
   hex2ascii_stream #(.NBYTES(2), .LOWERCASE(1'b1), .PREFIX_EN(1'b1), .CRLF_EN(1'b0))
      u_pfx (.clk(clk), .rst_n(rst_n), .bus(if1));
   hex2ascii_stream #(.NBYTES(2), .LZ_SUPPRESS(1'b1)) u_lz (.clk(clk), .rst_n(rst_n), .bus(if2));
   hex2ascii_stream #(.NBYTES(4)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(if3));

   logic       ov, ol, ir, bsy;
   logic [7:0] oc;
   always_comb begin
      ov = if0.out_valid; oc = if0.out_char; ol = if0.out_last; ir = if0.in_ready; bsy = if0.busy;
      case (sel)
         2'd1: begin
            ov = if1.out_valid; oc = if1.out_char; ol = if1.out_last;
            ir = if1.in_ready; bsy = if1.busy;
         end
         2'd2: begin
            ov = if2.out_valid; oc = if2.out_char; ol = if2.out_last;
            ir = if2.in_ready; bsy = if2.busy;
         end
         2'd3: begin
            ov = if3.out_valid; oc = if3.out_char; ol = if3.out_last;
            ir = if3.in_ready; bsy = if3.busy;
         end
         default: ;
      endcase
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         stall_bad, ir_bad, busy_hs;

   task automatic push(input logic [7:0] c, input logic l);
      exp_q.push_back({l, c});
   endtask

   // Waits for in_ready, presents the word for one cycle; returns at the negedge after accept.
   task automatic accept(input logic [63:0] d, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (ir) begin
            din = d;
            vin[sel] = 1'b1;
            ok = 1'b1;
         end
      end
      @(negedge clk);
      vin = '0;
   endtask

   // Captures n output handshakes; ready pattern 1,0,0 repeating when toggle is set.
   task automatic collect(input int n, input bit toggle, input int pulse_at, output bit to);
      logic [7:0] pc;
      logic       pl;
      bit         pstall;
      got_q.delete();
      stall_bad = 0; ir_bad = 0; busy_hs = 0; to = 1'b1; pstall = 1'b0; pc = '0; pl = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (k > 0) @(negedge clk);
         ordy = toggle ? (k % 3 == 0) : 1'b1;
         vin[sel] = (k == pulse_at);
         if (pstall && (oc !== pc || ol !== pl)) stall_bad++;
         if (ir) ir_bad++;
         if (ov && ordy) begin
            got_q.push_back({ol, oc});
            if (bsy) busy_hs++;
         end
         pstall = ov && !ordy;
         pc = oc;
         pl = ol;
         if (got_q.size() >= n) begin
            to = 1'b0;
            break;
         end
      end
      vin = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         n_cmp++;
         if ({ir, ov, oc, ol, bsy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state dut%0d got ir=%b ov=%b oc=%h ol=%b busy=%b want 1 0 00 0 0",
                     s, ir, ov, oc, ol, bsy);
         end
      end
      sel = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release got ir=%b ov=%b want 1 0", ir, ov);
      end
   endtask

   task automatic test_default();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd0; ordy = 1'b1;
      push(8'h33, 0); push(8'h41, 0); push(8'h37, 0); push(8'h46, 0); push(8'h0D, 0); push(8'h0A, 1);
      accept(64'h3A7F, ok);
      n_cmp++;
      if (!ok || ov !== 1'b1 || bsy !== 1'b1 || ir !== 1'b0) begin
         n_bad++;
         $display("FAIL default_latency got ok=%b ov=%b busy=%b ir=%b want 1 1 1 0", ok, ov, bsy, ir);
      end
      collect(6, 1'b0, -1, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL default_timeout got %0d chars want 6", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL default_char got %h want %h", g, e); end
      end
      n_cmp++;
      if (busy_hs !== 6) begin n_bad++; $display("FAIL default_busy got %0d want 6", busy_hs); end
      @(negedge clk);
      n_cmp++;
      if (ov !== 1'b0 || bsy !== 1'b0 || ir !== 1'b1) begin
         n_bad++;
         $display("FAIL default_done got ov=%b busy=%b ir=%b want 0 0 1", ov, bsy, ir);
      end
   endtask

   task automatic test_prefix_lower();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd1; ordy = 1'b1;
      push(8'h30, 0); push(8'h78, 0); push(8'h62, 0); push(8'h65, 0); push(8'h65, 0); push(8'h66, 1);
      accept(64'hBEEF, ok);
      collect(6, 1'b0, -1, to);
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL prefix_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL prefix_char got %h want %h", g, e); end
      end
      @(negedge clk);
      n_cmp++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
         n_bad++;
         $display("FAIL prefix_done got ov=%b ir=%b want 0 1", ov, ir);
      end
   endtask

   task automatic test_lz_suppress();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd2; ordy = 1'b1;
      push(8'h30, 0); push(8'h0D, 0); push(8'h0A, 1);
      accept(64'h0000, ok);
      collect(3, 1'b0, -1, to);
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL lz_zero_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL lz_zero_char got %h want %h", g, e); end
      end
      push(8'h43, 0); push(8'h34, 0); push(8'h0D, 0); push(8'h0A, 1);
      accept(64'h00C4, ok);
      collect(4, 1'b0, -1, to);
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL lz_c4_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL lz_c4_char got %h want %h", g, e); end
      end
   endtask

   task automatic test_backpressure();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd0; ordy = 1'b1;
      push(8'h31, 0); push(8'h32, 0); push(8'h33, 0); push(8'h34, 0); push(8'h0D, 0); push(8'h0A, 1);
      accept(64'h1234, ok);
      collect(6, 1'b1, 2, to);
      ordy = 1'b1;
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL stall_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL stall_char got %h want %h", g, e); end
      end
      n_cmp++;
      if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_hold got %0d changes want 0", stall_bad); end
      n_cmp++;
      if (ir_bad !== 0) begin n_bad++; $display("FAIL stall_in_ready got %0d high want 0", ir_bad); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (ov !== 1'b0 || bsy !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_ignored_word got ov=%b busy=%b want 0 0", ov, bsy);
         end
      end
   endtask

   task automatic test_wide_word();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd3; ordy = 1'b1;
      push(8'h44, 0); push(8'h45, 0); push(8'h41, 0); push(8'h44, 0);
      push(8'h42, 0); push(8'h45, 0); push(8'h45, 0); push(8'h46, 0);
      push(8'h0D, 0); push(8'h0A, 1);
      accept(64'hDEADBEEF, ok);
      collect(10, 1'b0, -1, to);
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL wide_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL wide_char got %h want %h", g, e); end
      end
   endtask

   task automatic test_reset_mid_word();
      bit ok, to;
      logic [8:0] e, g;
      sel = 2'd0; ordy = 1'b1;
      @(negedge clk);
      accept(64'h3A7F, ok);
      collect(2, 1'b0, -1, to);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ov !== 1'b0 || bsy !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_abort got ov=%b busy=%b want 0 0", ov, bsy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_release got ir=%b ov=%b want 1 0", ir, ov);
      end
      push(8'h30, 0); push(8'h30, 0); push(8'h30, 0); push(8'h31, 0); push(8'h0D, 0); push(8'h0A, 1);
      accept(64'h0001, ok);
      collect(6, 1'b0, -1, to);
      n_cmp++;
      if (!ok || to) begin n_bad++; $display("FAIL midreset_timeout got ok=%b to=%b want 1 0", ok, to); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 9'h1FF;
         if (got_q.size() > 0) g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL midreset_char got %h want %h", g, e); end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_prefix_lower();
      test_lz_suppress();
      test_backpressure();
      test_wide_word();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
